// File: rtl/branch_redirect_unit.sv
// Branch redirect unit: resolves RV64I conditional branches, JAL and JALR, and
// drives the fetch redirect (pc_branch/select). It squashes FLUSH_CYCLES
// wrong-path instructions after each redirect.
// Optional feature macro: BRU_STATS_EN adds the 32-bit redirect_count output.
module branch_redirect_unit #(
   parameter int unsigned FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instruction,
   input  logic        inst_valid,
   input  logic [63:0] pc,
   input  logic [63:0] rs1_data,
   input  logic [63:0] rs2_data,
`ifdef BRU_STATS_EN
   output logic [31:0] redirect_count,
`endif
   output logic [63:0] pc_branch,
   output logic        select,
   output logic        squash
);

   localparam logic [6:0] OpBranch = 7'b1100011;
   localparam logic [6:0] OpJal    = 7'b1101111;
   localparam logic [6:0] OpJalr   = 7'b1100111;
   localparam logic [3:0] FlushLd  = 4'(FLUSH_CYCLES);

   typedef enum logic [0:0] {StIdle, StFlush} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [63:0] pc_branch_q, pc_branch_d;
   logic        select_q, select_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [63:0] imm_b, imm_j, imm_i;
   logic        taken;
   logic [63:0] target;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign imm_b  = {{51{instruction[31]}}, instruction[31], instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
   assign imm_j  = {{43{instruction[31]}}, instruction[31], instruction[19:12],
                    instruction[20], instruction[30:21], 1'b0};
   assign imm_i  = {{52{instruction[31]}}, instruction[31:20]};

   // Decode: branch condition evaluation and target computation
   always_comb begin
      taken  = 1'b0;
      target = pc + imm_b;
      unique case (opcode)
         OpBranch: begin
            target = pc + imm_b;
            case (funct3)
               3'b000:  taken = (rs1_data == rs2_data);
               3'b001:  taken = (rs1_data != rs2_data);
               3'b100:  taken = ($signed(rs1_data) <  $signed(rs2_data));
               3'b101:  taken = ($signed(rs1_data) >= $signed(rs2_data));
               3'b110:  taken = (rs1_data <  rs2_data);
               3'b111:  taken = (rs1_data >= rs2_data);
               default: taken = 1'b0;
            endcase
         end
         OpJal: begin
            taken  = 1'b1;
            target = pc + imm_j;
         end
         OpJalr: begin
            taken  = 1'b1;
            target = (rs1_data + imm_i) & ~64'h1;
         end
         default: taken = 1'b0;
      endcase
   end

   // Next-state: redirect only from IDLE; FLUSH counts down wrong-path slots
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pc_branch_d = pc_branch_q;
      select_d    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (inst_valid && taken) begin
               pc_branch_d = target;
               select_d    = 1'b1;
               if (FlushLd != 4'd0) begin
                  cnt_d   = FlushLd;
                  state_d = StFlush;
               end
            end
         end
         StFlush: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         cnt_q       <= 4'd0;
         pc_branch_q <= 64'd0;
         select_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pc_branch_q <= pc_branch_d;
         select_q    <= select_d;
      end
   end

   assign pc_branch = pc_branch_q;
   assign select    = select_q;
   assign squash    = (state_q == StFlush);

`ifdef BRU_STATS_EN
   logic [31:0] count_q;

   // Redirect statistics: counts cycles with select high, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= 32'd0;
      end else if (select_q) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign redirect_count = count_q;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed bench for branch_redirect_unit with FLUSH_CYCLES = 2.
module tb_branch_redirect_unit;

   logic        clk;
   logic        reset;
   logic [31:0] instruction;
   logic        inst_valid;
   logic [63:0] pc;
   logic [63:0] rs1_data;
   logic [63:0] rs2_data;
   logic [63:0] pc_branch;
   logic        select;
   logic        squash;
`ifdef BRU_STATS_EN
   logic [31:0] redirect_count;
`endif

   int tests;
   int failed;

   branch_redirect_unit #(.FLUSH_CYCLES(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .instruction (instruction),
      .inst_valid  (inst_valid),
      .pc          (pc),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
`ifdef BRU_STATS_EN
      .redirect_count (redirect_count),
`endif
      .pc_branch   (pc_branch),
      .select      (select),
      .squash      (squash)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock, then sample 1 time unit after the rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] ins, input logic [63:0] p,
                        input logic [63:0] a, input logic [63:0] b);
      instruction = ins;
      pc          = p;
      rs1_data    = a;
      rs2_data    = b;
      inst_valid  = 1'b1;
   endtask

   initial begin
      tests       = 0;
      failed      = 0;
      reset       = 1'b0;
      inst_valid  = 1'b0;
      instruction = 32'h0;
      pc          = 64'h0;
      rs1_data    = 64'h0;
      rs2_data    = 64'h0;

      step();
      check("reset_select", {63'd0, select}, 64'd0);
      check("reset_squash", {63'd0, squash}, 64'd0);
      check("reset_pc_branch", pc_branch, 64'd0);
`ifdef BRU_STATS_EN
      check("reset_count", {32'd0, redirect_count}, 64'd0);
`endif
      reset = 1'b1;
      step();
      check("idle_select", {63'd0, select}, 64'd0);

      // BEQ x1,x2,+16 taken
      drive(32'h00208863, 64'h100, 64'd5, 64'd5);
      step();
      inst_valid = 1'b0;
      check("beq_select", {63'd0, select}, 64'd1);
      check("beq_target", pc_branch, 64'h110);
      check("beq_squash1", {63'd0, squash}, 64'd1);
      step();
      check("beq_select_pulse", {63'd0, select}, 64'd0);
      check("beq_squash2", {63'd0, squash}, 64'd1);
      step();
      check("beq_squash_end", {63'd0, squash}, 64'd0);
      check("beq_target_hold", pc_branch, 64'h110);

      // BNE with equal operands: not taken
      drive(32'h00209863, 64'h180, 64'd7, 64'd7);
      step();
      inst_valid = 1'b0;
      check("bne_select", {63'd0, select}, 64'd0);
      check("bne_squash", {63'd0, squash}, 64'd0);
      check("bne_target_hold", pc_branch, 64'h110);

      // Reserved funct3 010: never taken
      drive(32'h0020A863, 64'h180, 64'd7, 64'd7);
      step();
      inst_valid = 1'b0;
      check("f3_010_select", {63'd0, select}, 64'd0);

      // BLT signed: -1 < 1 taken
      drive(32'h0020C863, 64'h200, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      check("blt_select", {63'd0, select}, 64'd1);
      check("blt_target", pc_branch, 64'h210);
      // Taken BEQ presented during FLUSH must be ignored
      drive(32'h00208863, 64'h300, 64'd9, 64'd9);
      step();
      inst_valid = 1'b0;
      check("flush_ignore_select", {63'd0, select}, 64'd0);
      check("flush_ignore_target", pc_branch, 64'h210);
      check("flush_squash", {63'd0, squash}, 64'd1);
      step();
      check("blt_squash_end", {63'd0, squash}, 64'd0);

      // BLTU unsigned: 0xFFFF... < 1 false
      drive(32'h0020E863, 64'h400, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
      step();
      inst_valid = 1'b0;
      check("bltu_select", {63'd0, select}, 64'd0);
      check("bltu_target_hold", pc_branch, 64'h210);

      // JALR x0, 4(x1) with rs1 = 0x2001: bit 0 cleared
      drive(32'h00408067, 64'h500, 64'h2001, 64'd0);
      step();
      inst_valid = 1'b0;
      check("jalr_select", {63'd0, select}, 64'd1);
      check("jalr_target", pc_branch, 64'h2004);
      step();
      step();
      check("jalr_squash_end", {63'd0, squash}, 64'd0);

      // JAL -4 at pc 0 wraps
      drive(32'hFFDFF06F, 64'h0, 64'd0, 64'd0);
      step();
      inst_valid = 1'b0;
      check("jal_select", {63'd0, select}, 64'd1);
      check("jal_target", pc_branch, 64'hFFFF_FFFF_FFFF_FFFC);
      step();
      check("jal_squash_mid", {63'd0, squash}, 64'd1);
`ifdef BRU_STATS_EN
      check("stats_count", {32'd0, redirect_count}, 64'd4);
`endif
      // Asynchronous reset mid-FLUSH
      reset = 1'b0;
      #1;
      check("rst_mid_select", {63'd0, select}, 64'd0);
      check("rst_mid_squash", {63'd0, squash}, 64'd0);
      check("rst_mid_target", pc_branch, 64'd0);
`ifdef BRU_STATS_EN
      check("rst_mid_count", {32'd0, redirect_count}, 64'd0);
`endif
      step();
      reset = 1'b1;
      step();
      check("post_rst_squash", {63'd0, squash}, 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
